// File: rtl/bmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bmem_port_arbiter                                                 |
// | Purpose: Round-robin arbiter granting whole burst transactions from N      |
// |          cache-side ports onto one burst memory interface. Read beats are  |
// |          steered back to the owning port; an AMO lock pins the grant to    |
// |          one port across consecutive transactions.                         |
// | Ports  : clk/rst (async, active-low)                                       |
// |          port_* : per-port request side (packed slices, p = port index)    |
// |          bmem_* : single burst memory side                                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module bmem_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  input  logic [NUM_PORTS-1:0]        port_read,
  input  logic [NUM_PORTS-1:0]        port_write,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
  input  logic [NUM_PORTS-1:0]        port_lock,
  output logic [NUM_PORTS-1:0]        port_wready,
  output logic [DATA_W-1:0]           port_rdata,
  output logic [NUM_PORTS-1:0]        port_rvalid,
  output logic [NUM_PORTS-1:0]        port_done,
  output logic [ADDR_W-1:0]           bmem_addr,
  output logic                        bmem_read,
  output logic                        bmem_write,
  output logic [DATA_W-1:0]           bmem_wdata,
  input  logic                        bmem_ready,
  input  logic [ADDR_W-1:0]           bmem_raddr,
  input  logic [DATA_W-1:0]           bmem_rdata,
  input  logic                        bmem_rvalid
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] C_LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [PW-1:0] C_LAST_PORT = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_READ_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PW-1:0]       r_grant;
  logic [CW-1:0]       r_cnt;
  logic [PW-1:0]       r_rr;
  logic                r_locked;
  logic [ADDR_W-1:0]   r_addr;

  logic [NUM_PORTS-1:0] w_req;
  logic                 w_lock_eff;
  logic [PW-1:0]        w_cand;
  logic                 w_cand_vld;
  logic                 w_cand_wr;
  logic                 w_issue;
  logic                 w_beat;
  logic                 w_complete;

  // Port index base+off wrapped into [0, NUM_PORTS); works for any port count.
  function automatic logic [PW-1:0] f_rot(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PW'(s);
  endfunction

  assign w_req      = port_read | port_write;
  // The lock only holds while the owning port keeps port_lock high; dropping
  // it in IDLE releases arbitration in the same cycle.
  assign w_lock_eff = r_locked & port_lock[r_grant];
  assign w_cand_wr  = port_write[w_cand];

  // Candidate search: walk downward so the port closest to r_rr wins last.
  always_comb begin
    w_cand     = r_grant;
    w_cand_vld = 1'b0;
    if (w_lock_eff) begin
      w_cand_vld = w_req[r_grant];
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (w_req[f_rot(r_rr, i)]) begin
          w_cand     = f_rot(r_rr, i);
          w_cand_vld = 1'b1;
        end
      end
    end
  end

  // Next state and outputs. Everything is qualified by rst so that outputs
  // drop to zero the instant reset is asserted, independent of the clock.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_beat      = 1'b0;
    w_complete  = 1'b0;
    port_wready = '0;
    port_rdata  = '0;
    port_rvalid = '0;
    port_done   = '0;
    bmem_addr   = '0;
    bmem_read   = 1'b0;
    bmem_write  = 1'b0;
    bmem_wdata  = '0;
    if (rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_cand_vld && bmem_ready) begin
            w_issue   = 1'b1;
            bmem_addr = port_addr[w_cand*ADDR_W +: ADDR_W];
            // A port asserting both read and write gets the write.
            if (w_cand_wr) begin
              bmem_write          = 1'b1;
              bmem_wdata          = port_wdata[w_cand*DATA_W +: DATA_W];
              port_wready[w_cand] = 1'b1;
              w_state_nxt         = S_WRITE;
            end else begin
              bmem_read   = 1'b1;
              w_state_nxt = S_READ_WAIT;
            end
          end
        end
        S_WRITE: begin
          bmem_write = 1'b1;
          bmem_addr  = r_addr;
          bmem_wdata = port_wdata[r_grant*DATA_W +: DATA_W];
          if (bmem_ready) begin
            port_wready[r_grant] = 1'b1;
            w_beat               = 1'b1;
            if (r_cnt == C_LAST_BEAT) begin
              port_done[r_grant] = 1'b1;
              w_complete         = 1'b1;
              w_state_nxt        = S_IDLE;
            end
          end
        end
        S_READ_WAIT: begin
          port_rdata           = bmem_rdata;
          port_rvalid[r_grant] = bmem_rvalid;
          if (bmem_rvalid) begin
            w_beat = 1'b1;
            if (r_cnt == C_LAST_BEAT) begin
              port_done[r_grant] = 1'b1;
              w_complete         = 1'b1;
              w_state_nxt        = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_cnt    <= '0;
      r_rr     <= '0;
      r_locked <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) r_locked <= w_lock_eff;
      if (w_issue) begin
        r_grant <= w_cand;
        r_addr  <= port_addr[w_cand*ADDR_W +: ADDR_W];
        // The first write beat goes out with the command itself.
        r_cnt   <= w_cand_wr ? CW'(1) : '0;
      end else if (w_beat) begin
        // Wraps back to zero after the last beat (BURST_LEN is a power of two).
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_complete) begin
        if (port_lock[r_grant]) begin
          r_locked <= 1'b1;
        end else begin
          r_locked <= 1'b0;
          r_rr     <= (r_grant == C_LAST_PORT) ? '0 : r_grant + PW'(1);
        end
      end
    end
  end

  // Returning bursts must belong to the outstanding read.
  a_raddr_match: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_READ_WAIT && bmem_rvalid) |-> (bmem_raddr == r_addr));

endmodule
`default_nettype wire

// File: tb/tb_bmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_bmem_port_arbiter                                              |
// | Purpose: Self-checking bench for bmem_port_arbiter. A transaction-level    |
// |          model (grant choice, beat counts, lock/rr bookkeeping) predicts   |
// |          every cycle's outputs; scenario tasks add directed checks.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_bmem_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N*AW-1:0] port_addr = '0;
  logic [N-1:0]    port_read = '0;
  logic [N-1:0]    port_write = '0;
  logic [N*DW-1:0] port_wdata = '0;
  logic [N-1:0]    port_lock = '0;
  logic [N-1:0]    port_wready;
  logic [DW-1:0]   port_rdata;
  logic [N-1:0]    port_rvalid;
  logic [N-1:0]    port_done;
  logic [AW-1:0]   bmem_addr;
  logic            bmem_read;
  logic            bmem_write;
  logic [DW-1:0]   bmem_wdata;
  logic            bmem_ready = 1'b1;
  logic [AW-1:0]   bmem_raddr = '0;
  logic [DW-1:0]   bmem_rdata = '0;
  logic            bmem_rvalid = 1'b0;

  always #5 clk = ~clk;

  bmem_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .port_addr(port_addr), .port_read(port_read), .port_write(port_write),
    .port_wdata(port_wdata), .port_lock(port_lock), .port_wready(port_wready),
    .port_rdata(port_rdata), .port_rvalid(port_rvalid), .port_done(port_done),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  int vec  = 0;
  int miss = 0;

  // Requester side
  bit            p_rd [N];
  bit            p_wr [N];
  bit            p_lock [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_wdat [N][BL];
  int            p_widx [N];
  bit            hold_lock [N];
  bit            nx_valid [N];
  bit            nx_rd [N];
  bit            nx_wr [N];
  bit            nx_lock [N];
  logic [AW-1:0] nx_addr [N];

  // Reference model: 0 idle, 1 writing, 2 waiting for read beats
  int            m_mode = 0;
  int            m_g = 0;
  int            m_beats = 0;
  int            m_rr = 0;
  bit            m_locked = 0;
  logic [AW-1:0] m_addr = '0;

  // Memory behaviour and observations
  bit            rand_fill = 0;
  bit            rand_ready = 0;
  int            stall_left = 0;
  int            stall_beat = 0;
  int            stall_seen = 0;
  int            n_read = 0;
  int            wr_pulses [N];
  logic [DW-1:0] rd_script [$];
  logic [DW-1:0] rx [N][$];
  int            glog [$];
  int            cyc = 0;

  function automatic int pick();
    if (m_locked && p_lock[m_g]) return (p_rd[m_g] || p_wr[m_g]) ? m_g : -1;
    for (int i = 0; i < N; i++) begin
      int q;
      q = (m_rr + i) % N;
      if (p_rd[q] || p_wr[q]) return q;
    end
    return -1;
  endfunction

  function automatic bit any_req();
    for (int p = 0; p < N; p++) if (p_rd[p] || p_wr[p]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_ports();
    for (int p = 0; p < N; p++) begin
      port_read[p]             = p_rd[p];
      port_write[p]            = p_wr[p];
      port_lock[p]             = p_lock[p];
      port_addr[p*AW +: AW]    = p_addr[p];
      port_wdata[p*DW +: DW]   = p_wdat[p][p_widx[p]];
    end
  endtask

  task automatic clear_ports();
    for (int p = 0; p < N; p++) begin
      p_rd[p] = 0; p_wr[p] = 0; p_lock[p] = 0; p_addr[p] = '0; p_widx[p] = 0;
      hold_lock[p] = 0; nx_valid[p] = 0; wr_pulses[p] = 0; rx[p].delete();
      for (int b = 0; b < BL; b++) p_wdat[p][b] = {$urandom, $urandom};
    end
  endtask

  task automatic load_rand(input int p);
    int k;
    k = $urandom_range(0, 5);
    p_wr[p]   = (k >= 3);
    p_rd[p]   = (k <= 3);
    p_addr[p] = $urandom & 32'hFFFF_FFE0;
    p_lock[p] = ($urandom_range(0, 3) == 0);
    p_widx[p] = 0;
    for (int b = 0; b < BL; b++) p_wdat[p][b] = {$urandom, $urandom};
  endtask

  task automatic model_reset();
    m_mode = 0; m_g = 0; m_beats = 0; m_rr = 0; m_locked = 0; m_addr = '0;
    stall_left = 0; rd_script.delete();
  endtask

  // One clock: drive at the falling edge, check 1ns later, advance model.
  task automatic cycle();
    int            g, mode0;
    bit            fin;
    logic          e_read, e_write;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [N-1:0]  e_wready, e_rvalid, e_done;
    @(negedge clk);
    cyc++;
    if (rand_fill)
      for (int p = 0; p < N; p++)
        if (!p_rd[p] && !p_wr[p] && $urandom_range(0, 3) == 0) load_rand(p);
    drive_ports();
    if (stall_left > 0 && m_mode == 1 && m_beats == stall_beat) begin
      bmem_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) bmem_ready = ($urandom_range(0, 3) != 0);
    else bmem_ready = 1'b1;
    bmem_rvalid = 1'b0;
    bmem_raddr  = m_addr;
    bmem_rdata  = {$urandom, $urandom};
    if (m_mode == 2) begin
      if ($urandom_range(0, 3) != 0) begin
        bmem_rvalid = 1'b1;
        if (rd_script.size() > 0) bmem_rdata = rd_script.pop_front();
      end
    end else if ($urandom_range(0, 7) == 0) bmem_rvalid = 1'b1;
    #1;
    mode0 = m_mode; fin = 0;
    e_read = 0; e_write = 0; e_addr = '0; e_wdata = '0;
    e_wready = '0; e_rvalid = '0; e_done = '0;
    case (mode0)
      0: begin
        g = pick();
        if (m_locked && !p_lock[m_g]) m_locked = 0;
        if (g >= 0 && bmem_ready) begin
          m_g = g; m_addr = p_addr[g]; e_addr = p_addr[g];
          if (p_wr[g]) begin
            e_write = 1; e_wdata = p_wdat[g][p_widx[g]]; e_wready[g] = 1;
            m_beats = 1; m_mode = 1;
          end else begin
            e_read = 1; m_beats = 0; m_mode = 2;
          end
        end
      end
      1: begin
        e_write = 1; e_addr = m_addr; e_wdata = p_wdat[m_g][p_widx[m_g]];
        if (bmem_ready) begin
          e_wready[m_g] = 1; m_beats++;
          if (m_beats == BL) fin = 1;
        end
      end
      default: begin
        if (bmem_rvalid) begin
          e_rvalid[m_g] = 1; m_beats++;
          if (m_beats == BL) fin = 1;
        end
      end
    endcase
    if (fin) begin
      e_done[m_g] = 1;
      if (p_lock[m_g]) m_locked = 1;
      else begin m_locked = 0; m_rr = (m_g + 1) % N; end
      m_mode = 0;
      glog.push_back(m_g);
    end
    vec++;
    if ({bmem_read, bmem_write, port_wready, port_rvalid, port_done} !==
        {e_read, e_write, e_wready, e_rvalid, e_done}) begin
      miss++;
      $display("FAIL ctl cyc=%0d got rd=%b wr=%b wrdy=%b rv=%b done=%b, want rd=%b wr=%b wrdy=%b rv=%b done=%b",
               cyc, bmem_read, bmem_write, port_wready, port_rvalid, port_done,
               e_read, e_write, e_wready, e_rvalid, e_done);
    end
    if (e_read || e_write) begin
      vec++;
      if (bmem_addr !== e_addr) begin
        miss++;
        $display("FAIL addr cyc=%0d got %h want %h", cyc, bmem_addr, e_addr);
      end
    end
    if (e_write) begin
      vec++;
      if (bmem_wdata !== e_wdata) begin
        miss++;
        $display("FAIL wdata cyc=%0d got %h want %h", cyc, bmem_wdata, e_wdata);
      end
    end
    if (mode0 == 2) begin
      vec++;
      if (port_rdata !== bmem_rdata) begin
        miss++;
        $display("FAIL rdata cyc=%0d got %h want %h", cyc, port_rdata, bmem_rdata);
      end
    end
    if (bmem_read === 1'b1) n_read++;
    if (bmem_write === 1'b1 && bmem_ready === 1'b0) stall_seen++;
    for (int p = 0; p < N; p++) begin
      if (port_wready[p] === 1'b1) wr_pulses[p]++;
      if (port_rvalid[p] === 1'b1) rx[p].push_back(port_rdata);
      if (e_wready[p] && p_widx[p] < BL - 1) p_widx[p]++;
      if (e_done[p]) begin
        p_widx[p] = 0;
        if (nx_valid[p]) begin
          p_rd[p] = nx_rd[p]; p_wr[p] = nx_wr[p];
          p_addr[p] = nx_addr[p]; p_lock[p] = nx_lock[p]; nx_valid[p] = 0;
        end else begin
          p_rd[p] = 0; p_wr[p] = 0;
          if (!hold_lock[p]) p_lock[p] = 0;
        end
      end
    end
  endtask

  task automatic run(input int n, input int maxc);
    int target, c;
    target = glog.size() + n;
    c = 0;
    while (glog.size() < target && c < maxc) begin cycle(); c++; end
    vec++;
    if (glog.size() < target) begin
      miss++;
      $display("FAIL timeout completions got %0d want %0d", glog.size(), target);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    vec++;
    if ({bmem_read, bmem_write, bmem_addr, bmem_wdata, port_wready, port_rvalid, port_done, port_rdata} !== '0) begin
      miss++;
      $display("FAIL %s got rd=%b wr=%b addr=%h wrdy=%b rv=%b done=%b want all zero",
               name, bmem_read, bmem_write, bmem_addr, port_wready, port_rvalid, port_done);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_ports();
    drive_ports();
    bmem_rvalid = 1'b0;
    bmem_ready  = 1'b1;
    model_reset();
    #1;
    check_zero_outputs("reset_outputs");
    @(negedge clk);
    rst = 1'b1;
    glog.delete();
  endtask

  task automatic check_log(input string name, input int a [$]);
    vec++;
    if (glog != a) begin
      miss++;
      $display("FAIL %s grant order got %p want %p", name, glog, a);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_ports();
    model_reset();
    p_rd[2] = 1; p_wr[0] = 1; p_addr[2] = 32'h55;
    drive_ports();
    bmem_rvalid = 1'b1;
    bmem_ready  = 1'b1;
    #1;
    check_zero_outputs("reset_with_requests");
    @(negedge clk);
    clear_ports();
    drive_ports();
    bmem_rvalid = 1'b0;
    rst = 1'b1;
    repeat (3) cycle();
    vec++;
    if (n_read != 0) begin
      miss++;
      $display("FAIL reset_idle read commands got %0d want 0", n_read);
    end
  endtask

  task automatic test_single_read();
    logic [DW-1:0] beats [BL];
    beats[0] = 64'hAAAA_0000_0000_000A; beats[1] = 64'hBBBB_0000_0000_000B;
    beats[2] = 64'hCCCC_0000_0000_000C; beats[3] = 64'hDDDD_0000_0000_000D;
    do_reset();
    for (int b = 0; b < BL; b++) rd_script.push_back(beats[b]);
    n_read = 0;
    p_rd[2] = 1; p_addr[2] = 32'h0000_1000;
    run(1, 200);
    check_log("single_read", '{2});
    vec++;
    if (n_read != 1) begin
      miss++;
      $display("FAIL single_read commands got %0d want 1", n_read);
    end
    vec++;
    if (rx[2].size() != BL || rx[2][0] !== beats[0] || rx[2][1] !== beats[1] ||
        rx[2][2] !== beats[2] || rx[2][3] !== beats[3]) begin
      miss++;
      $display("FAIL single_read beats got %p want %p", rx[2], beats);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int p = 0; p < N; p++) begin p_rd[p] = 1; p_addr[p] = 32'h4000 + p * 32'h100; end
    run(4, 400);
    check_log("rr_all", '{0, 1, 2, 3});
    glog.delete();
    p_rd[0] = 1; p_rd[3] = 1;
    run(2, 200);
    check_log("rr_wrap", '{0, 3});
  endtask

  task automatic test_write_stall();
    do_reset();
    p_wr[1] = 1; p_addr[1] = 32'h3000;
    for (int b = 0; b < BL; b++) p_wdat[1][b] = 64'h1111_0000_0000_0000 * (b + 1);
    stall_beat = 2; stall_left = 3; stall_seen = 0;
    run(1, 200);
    check_log("write_stall", '{1});
    vec++;
    if (wr_pulses[1] != BL) begin
      miss++;
      $display("FAIL write_stall wready pulses got %0d want %0d", wr_pulses[1], BL);
    end
    vec++;
    if (stall_seen != 3) begin
      miss++;
      $display("FAIL write_stall held cycles got %0d want 3", stall_seen);
    end
  endtask

  task automatic test_lock();
    int reads0;
    do_reset();
    p_rd[0] = 1; p_addr[0] = 32'h100; p_lock[0] = 1; hold_lock[0] = 1;
    p_rd[1] = 1; p_addr[1] = 32'h200;
    nx_valid[0] = 1; nx_rd[0] = 1; nx_wr[0] = 0; nx_addr[0] = 32'h180; nx_lock[0] = 1;
    run(2, 300);
    check_log("lock_hold", '{0, 0});
    reads0 = n_read;
    repeat (6) cycle();
    vec++;
    if (n_read != reads0 || glog.size() != 2) begin
      miss++;
      $display("FAIL lock_wait commands got %0d want 0", n_read - reads0);
    end
    hold_lock[0] = 0; p_lock[0] = 0;
    run(1, 200);
    check_log("lock_release", '{0, 0, 1});
  endtask

  task automatic test_rw_both();
    int reads0;
    do_reset();
    reads0 = n_read;
    p_rd[3] = 1; p_wr[3] = 1; p_addr[3] = 32'h7700;
    run(1, 200);
    check_log("rw_both", '{3});
    vec++;
    if (n_read != reads0 || wr_pulses[3] != BL) begin
      miss++;
      $display("FAIL rw_both got reads=%0d wready=%0d want reads=0 wready=%0d",
               n_read - reads0, wr_pulses[3], BL);
    end
  endtask

  task automatic test_reset_midread();
    int c;
    logic [DW-1:0] beats [BL];
    do_reset();
    for (int b = 0; b < BL; b++) rd_script.push_back({$urandom, $urandom});
    p_rd[1] = 1; p_addr[1] = 32'h2000;
    c = 0;
    while (!(m_mode == 2 && m_beats == 2) && c < 100) begin cycle(); c++; end
    vec++;
    if (!(m_mode == 2 && m_beats == 2)) begin
      miss++;
      $display("FAIL midread setup beats got %0d want 2", m_beats);
    end
    @(negedge clk);
    rst = 1'b0;
    bmem_rvalid = 1'b1; bmem_raddr = 32'h2000;
    #1;
    check_zero_outputs("midread_reset");
    model_reset();
    clear_ports();
    drive_ports();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bmem_rvalid = 1'b1; bmem_rdata = {$urandom, $urandom};
      #1;
      vec++;
      if (port_rvalid !== '0 || port_done !== '0 || bmem_read !== 1'b0) begin
        miss++;
        $display("FAIL stale_beat got rv=%b done=%b rd=%b want rv=0 done=0 rd=0",
                 port_rvalid, port_done, bmem_read);
      end
    end
    glog.delete();
    for (int b = 0; b < BL; b++) begin beats[b] = {$urandom, $urandom}; rd_script.push_back(beats[b]); end
    p_rd[1] = 1; p_addr[1] = 32'h2040;
    run(1, 200);
    check_log("midread_reissue", '{1});
    vec++;
    if (rx[1].size() != BL || rx[1][0] !== beats[0] || rx[1][3] !== beats[3]) begin
      miss++;
      $display("FAIL midread_reissue beats got %0d beats want %0d", rx[1].size(), BL);
    end
  endtask

  task automatic test_random();
    int c;
    do_reset();
    rand_fill = 1; rand_ready = 1;
    run(40, 4000);
    rand_fill = 0;
    c = 0;
    while ((any_req() || m_mode != 0) && c < 2000) begin cycle(); c++; end
    rand_ready = 0;
    vec++;
    if (any_req() || m_mode != 0) begin
      miss++;
      $display("FAIL random_drain still busy mode=%0d want idle", m_mode);
    end
  endtask

  initial begin
    clear_ports();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_stall();
    test_lock();
    test_rw_both();
    test_reset_midread();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim time %0t exceeded limit 500000", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/bmem_port_arbiter.md
# bmem_port_arbiter

Parametrised N-port arbiter between cache-side requesters (instruction/data caches of both cores) and the single burst memory interface that feeds the FPGA memory controller. Grants one whole burst transaction at a time using round-robin priority, routes read beats back to the owning port, and supports an AMO lock that pins the grant to one port across consecutive transactions. It replaces fixed two-core arbitration with a width-, depth- and port-count-generic block.

## Interface
- NUM_PORTS, 4: number of requester ports (≥2).
- ADDR_W, 32: address width.
- DATA_W, 64: beat width.
- BURST_LEN, 4: beats per read or write burst (power of two, ≥2).

- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- port_addr  in  NUM_PORTS*ADDR_W  per-port burst address, slice p = port p.
- port_read  in  NUM_PORTS  read request, held until port_done.
- port_write  in  NUM_PORTS  write request, held until port_done.
- port_wdata  in  NUM_PORTS*DATA_W  current write beat; advance on port_wready.
- port_lock  in  NUM_PORTS  keep grant after current transaction.
- port_wready  out  NUM_PORTS  write beat consumed this cycle.
- port_rdata  out  DATA_W  read beat (shared, qualify with port_rvalid).
- port_rvalid  out  NUM_PORTS  read beat valid for port p.
- port_done  out  NUM_PORTS  one-cycle pulse, transaction complete.
- bmem_addr  out  ADDR_W  burst address.
- bmem_read  out  1  one-cycle read command.
- bmem_write  out  1  write beat strobe.
- bmem_wdata  out  DATA_W  write beat.
- bmem_ready  in  1  memory accepts command/beat.
- bmem_raddr  in  ADDR_W  address of returning burst (checked, not routed).
- bmem_rdata  in  DATA_W  read beat.
- bmem_rvalid  in  1  read beat valid.

## Operation
- States: IDLE, WRITE, READ_WAIT. Registers: state, grant index, beat counter (log2 BURST_LEN bits), rr pointer, locked flag.
- IDLE: candidate = first requesting port (read|write) searching from rr pointer upward, wrapping. If locked, only the locked port is eligible; others wait.
- Port with both read and write asserted: write taken.
- IDLE, candidate exists, bmem_ready=1:
  - write: bmem_write=1, bmem_addr/wdata from port, port_wready[g]=1, counter←1, → WRITE.
  - read: bmem_read=1, bmem_addr from port, counter←0, → READ_WAIT.
  - bmem_ready=0: nothing driven, stay IDLE, re-evaluate next cycle.
- WRITE: bmem_write=1, bmem_addr held, wdata from granted port. Beat accepted when bmem_ready=1: port_wready[g]=1, counter++. On last beat (counter=BURST_LEN-1 accepted): port_done[g]=1, → IDLE.
- READ_WAIT: port_rdata=bmem_rdata, port_rvalid[g]=bmem_rvalid (combinational). Each rvalid increments counter; on beat BURST_LEN-1: port_done[g]=1, → IDLE.
- On completion: if port_lock[g]=1, locked←1 and rr pointer unchanged; else locked←0, rr pointer←(g+1) mod NUM_PORTS.
- bmem_rvalid in IDLE or WRITE ignored (no rvalid to any port).

## Timing
- Reset (rst=0, async): state IDLE, rr pointer 0, locked 0, counter 0; all outputs 0. Burst in flight abandoned; port must reissue.
- Read latency: command issued same cycle request is seen in IDLE with bmem_ready=1; data latency set by memory; port_done coincides with last rvalid.
- Write: minimum BURST_LEN cycles, one beat per bmem_ready cycle; port_done with last beat.
- One idle cycle minimum between transactions (completion → IDLE → next issue).
- Requests dropped mid-transaction: transaction still completes; port_done still pulses.
- port_lock deasserted while locked in IDLE: locked clears that cycle; normal round-robin resumes same cycle.

## Test plan
- Single read, port 2, addr 0x1000, rvalid beats A,B,C,D → bmem_read one cycle, addr 0x1000; port_rvalid[2] with A–D; port_done[2] on D; others silent.
- All 4 ports request reads simultaneously → grants in order 0,1,2,3; then ports 0 and 3 request → 0 (pointer wrapped to 0).
- Write port 1, bmem_ready low on beat 2 for 3 cycles → bmem_write held, wdata beat 2 stable, exactly 4 port_wready pulses, done after 4th.
- Port 0 locked for 2 transactions while port 1 requests → port 0 served twice, port 1 granted only after lock drops.
- Reset asserted in READ_WAIT after 2 beats → outputs 0 immediately; later rvalid beats produce no port_rvalid; fresh request served normally.
- Port with read and write both high → write burst executed.
